// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and parameter defaults.
// No logic here; the counter-width helper keeps zero-sized counters at one bit.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int GAP_TICKS_DFLT     = 16;
  localparam int TIMEOUT_TICKS_DFLT = 2048;

  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first set request at or above pointer, wrapping at N-1.
// Purely combinational, zero latency; no backpressure (valid simply follows |req).
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  output logic         valid,
  output logic [W-1:0] winner
);

  logic [W:0] idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      // one extra bit so pointer+i can be folded back into 0..N-1 for non-power-of-two N
      idx = {1'b0, pointer} + (W+1)'(i);
      if (idx >= (W+1)'(N)) idx = idx - (W+1)'(N);
      if (!valid && req[idx[W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte requesters, round-robin, with a tick-timed gap and BUSY timeout.
// Grant is registered one cycle after a request is seen in IDLE; requesters hold req/data until their ack pulse.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DBIT          = 8,
  parameter int GAP_TICKS     = GAP_TICKS_DFLT,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DFLT
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_tick,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*DBIT-1:0]    i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_tx_start,
  output logic [DBIT-1:0]          o_tx_data,
  input  logic                     i_tx_done,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam int IDW = $clog2(N_REQ);
  localparam int GW  = cnt_width(GAP_TICKS);
  localparam int TW  = cnt_width(TIMEOUT_TICKS);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_TICKS > 0) ? GW'(GAP_TICKS - 1) : '0;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic [TW-1:0]    to_cnt, to_nxt;
  logic [N_REQ-1:0] ack_nxt;
  logic             start_nxt;
  logic             err_nxt;
  logic             busy_nxt;
  logic [DBIT-1:0]  data_nxt;
  logic [IDW-1:0]   gid_nxt;
  logic             arb_vld;
  logic [IDW-1:0]   arb_win;
  logic             to_hit;
  logic [DBIT-1:0]  req_bytes [N_REQ];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_bytes[k] = i_data[k*DBIT +: DBIT];
    end
  end

  rr_arbiter #(
    .N (N_REQ),
    .W (IDW)
  ) u_arb (
    .req     (i_req),
    .pointer (ptr),
    .valid   (arb_vld),
    .winner  (arb_win)
  );

  assign to_hit = i_tick && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gap_nxt   = gap_cnt;
    to_nxt    = to_cnt;
    ack_nxt   = '0;
    start_nxt = 1'b0;
    err_nxt   = 1'b0;
    data_nxt  = o_tx_data;
    gid_nxt   = o_grant_id;

    case (state)
      ST_IDLE: begin
        if (arb_vld) begin
          state_nxt        = ST_START;
          data_nxt         = req_bytes[arb_win];
          gid_nxt          = arb_win;
          ack_nxt[arb_win] = 1'b1;
          ptr_nxt          = (arb_win == IDW'(N_REQ - 1)) ? '0 : arb_win + 1'b1;
        end
      end

      ST_START: begin
        state_nxt = ST_BUSY;
        start_nxt = 1'b1;
        to_nxt    = '0;
      end

      ST_BUSY: begin
        // a done pulse coinciding with the last timeout tick is a normal completion
        if (i_tx_done || to_hit) begin
          err_nxt = !i_tx_done;
          if (GAP_TICKS == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_GAP;
            gap_nxt   = GAP_LOAD;
          end
        end else if (i_tick && (to_cnt != '1)) begin
          to_nxt = to_cnt + 1'b1;
        end
      end

      ST_GAP: begin
        if (i_tick) begin
          if (gap_cnt == '0) state_nxt = ST_IDLE;
          else               gap_nxt   = gap_cnt - 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gap_cnt    <= '0;
      to_cnt     <= '0;
      o_ack      <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_grant_id <= '0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      gap_cnt    <= gap_nxt;
      to_cnt     <= to_nxt;
      o_ack      <= ack_nxt;
      o_tx_start <= start_nxt;
      o_tx_data  <= data_nxt;
      o_grant_id <= gid_nxt;
      o_busy     <= busy_nxt;
      o_err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int DB  = 8;
  localparam int GAP = 16;
  localparam int TO  = 32;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_tick;
  logic            i_tx_done;
  logic [N-1:0]    i_req;
  logic [N*DB-1:0] i_data;
  logic [N-1:0]    o_ack;
  logic            o_tx_start;
  logic [DB-1:0]   o_tx_data;
  logic [1:0]      o_grant_id;
  logic            o_busy;
  logic            o_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  int tick_mode = 0;

  always #5 i_clk = ~i_clk;

  uart_tx_scheduler #(
    .N_REQ         (N),
    .DBIT          (DB),
    .GAP_TICKS     (GAP),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_bound(input string nm);
    n_checks++;
    $display("FAIL %s: no response within cycle budget, required one (t=%0t)", nm, $time);
  endtask

  // Reference model: a frame is grant, start pulse, transmit until done or TO ticks, then GAP ticks of silence.
  int            m_ptr, m_age, m_ticks, m_gap, mk;
  bit            m_active, m_in_gap, m_found;
  logic [N-1:0]  e_ack;
  logic          e_start, e_err, e_busy;
  logic [DB-1:0] e_data;
  logic [1:0]    e_gid;

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m_ptr = 0; m_active = 0; m_in_gap = 0;
      e_ack = 0; e_start = 0; e_err = 0; e_busy = 0; e_data = 0; e_gid = 0;
    end else begin
      e_ack = 0; e_start = 0; e_err = 0;
      if (!m_active) begin
        m_found = 0;
        for (int s = 0; s < N; s++) begin
          mk = (m_ptr + s) % N;
          if (!m_found && i_req[mk]) begin
            m_found  = 1;
            e_ack    = 4'(1 << mk);
            e_data   = i_data[mk*DB +: DB];
            e_gid    = 2'(mk);
            m_ptr    = (mk + 1) % N;
            m_active = 1; m_age = 0; m_ticks = 0; m_in_gap = 0;
          end
        end
      end else begin
        m_age++;
        if (m_age == 1) begin
          e_start = 1;
        end else if (!m_in_gap) begin
          if (i_tx_done) begin
            m_in_gap = 1; m_gap = 0;
          end else if (i_tick) begin
            m_ticks++;
            if (m_ticks == TO) begin e_err = 1; m_in_gap = 1; m_gap = 0; end
          end
        end else if (i_tick) begin
          m_gap++;
          if (m_gap == GAP) m_active = 0;
        end
      end
      e_busy = m_active;
    end
  end

  always @(posedge i_clk) begin
    #2;
    if (chk_en) begin
      chk("cyc_ack",   32'(o_ack),      32'(e_ack));
      chk("cyc_start", 32'(o_tx_start), 32'(e_start));
      chk("cyc_data",  32'(o_tx_data),  32'(e_data));
      chk("cyc_gid",   32'(o_grant_id), 32'(e_gid));
      chk("cyc_busy",  32'(o_busy),     32'(e_busy));
      chk("cyc_err",   32'(o_err),      32'(e_err));
    end
  end

  task automatic step();
    @(negedge i_clk);
    i_tx_done = 1'b0;
    if (tick_mode == 0) i_tick = ~i_tick;
    else                i_tick = ($urandom_range(0, 2) == 0);
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  task automatic do_reset();
    i_reset = 1'b0;
    step();
    step();
    i_reset = 1'b1;
  endtask

  task automatic wait_ack(output int id);
    id = -1;
    for (int c = 0; c < 600; c++) begin
      step();
      if (o_ack != 0) begin
        id = oh_idx(o_ack);
        break;
      end
    end
    if (id < 0) fail_bound("ack_wait");
  endtask

  task automatic wait_idle(input int g0, output int g);
    g = g0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (!o_busy) return;
      chk("err_quiet_in_gap", 32'(o_err), 0);
      g += int'(i_tick);
    end
    fail_bound("idle_wait");
  endtask

  task automatic finish_frame();
    int g;
    step();
    chk("ack_one_cycle", 32'(o_ack), 0);
    chk("start_after_ack", 32'(o_tx_start), 1);
    i_tx_done = 1'b1;
    wait_idle(0, g);
  endtask

  task automatic run_frame(output int id);
    wait_ack(id);
    finish_frame();
  endtask

  int id, g, n;
  bit found;
  logic [N-1:0] pend;

  initial begin
    i_reset = 0; i_tick = 0; i_tx_done = 0; i_req = 0; i_data = 0;
    repeat (3) @(negedge i_clk);
    chk_en = 1'b1;
    chk("rst_ack",   32'(o_ack), 0);
    chk("rst_start", 32'(o_tx_start), 0);
    chk("rst_data",  32'(o_tx_data), 0);
    chk("rst_gid",   32'(o_grant_id), 0);
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_err",   32'(o_err), 0);

    // two requesters alternate: 0, 2, 0
    i_reset = 1;
    i_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    i_req   = 4'b0101;
    wait_ack(id);
    chk("first_ack", 32'(o_ack), 32'h1);
    chk("first_data", 32'(o_tx_data), 32'h11);
    finish_frame();
    run_frame(id); chk("rr_0101_second", id, 2);
    run_frame(id); chk("rr_0101_third", id, 0);

    // all four requesting for eight frames
    do_reset();
    i_req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      run_frame(id);
      chk("rr_1111_order", id, f % 4);
    end

    // byte 0xA5: start timing, data hold, 16-tick gap
    do_reset();
    i_data[7:0] = 8'hA5;
    i_req = 4'b0001;
    wait_ack(id);
    i_req = 4'b0000;
    chk("a5_latched", 32'(o_tx_data), 32'hA5);
    step();
    chk("a5_start", 32'(o_tx_start), 1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("a5_hold", 32'(o_tx_data), 32'hA5);
      chk("a5_start_single", 32'(o_tx_start), 0);
    end
    i_tx_done = 1'b1;
    wait_idle(0, g);
    chk("gap_ticks_after_done", g, GAP);
    chk("a5_after_frame", 32'(o_tx_data), 32'hA5);

    // no done: timeout on the 32nd BUSY tick, then a full gap
    i_data[15:8] = 8'h3C;
    i_req = 4'b0010;
    wait_ack(id);
    i_req = 4'b0000;
    step();
    n = int'(i_tick);
    found = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (o_err) begin found = 1; break; end
      n += int'(i_tick);
    end
    if (!found) fail_bound("timeout_err");
    else chk("timeout_tick_count", n, TO);
    chk("busy_after_err", 32'(o_busy), 1);
    wait_idle(int'(i_tick), g);
    chk("gap_ticks_after_timeout", g, GAP);

    // done lands on the timeout tick: completion wins
    i_data[7:0] = 8'h5A;
    i_req = 4'b0001;
    wait_ack(id);
    i_req = 4'b0000;
    step();
    n = int'(i_tick);
    found = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      n += int'(i_tick);
      if (i_tick && n == TO) begin i_tx_done = 1'b1; found = 1; break; end
    end
    if (!found) fail_bound("tie_setup");
    wait_idle(0, g);
    chk("tie_gap_ticks", g, GAP);

    // reset mid-frame, pointer must restart at 0
    i_req = 4'b0001;
    wait_ack(id);
    i_req = 4'b0000;
    step(); step();
    i_reset = 1'b0;
    step();
    chk("midrst_ack",   32'(o_ack), 0);
    chk("midrst_start", 32'(o_tx_start), 0);
    chk("midrst_data",  32'(o_tx_data), 0);
    chk("midrst_gid",   32'(o_grant_id), 0);
    chk("midrst_busy",  32'(o_busy), 0);
    chk("midrst_err",   32'(o_err), 0);
    i_req = 4'b1001;
    step();
    i_reset = 1'b1;
    wait_ack(id);
    chk("post_reset_grant", id, 0);
    i_req = 4'b1000;
    finish_frame();
    run_frame(id);
    chk("post_reset_req3", id, 3);

    // randomized traffic against the model
    tick_mode = 1;
    i_req = 0;
    pend = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c == 2000) i_reset = 1'b0;
      if (c == 2003) i_reset = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (o_ack[k]) begin
          if ($urandom_range(0, 1) == 0) begin
            pend[k] = 0; i_req[k] = 0;
          end else begin
            i_data[k*DB +: DB] = 8'($urandom);
          end
        end
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          pend[k] = 1; i_req[k] = 1;
          i_data[k*DB +: DB] = 8'($urandom);
        end
      end
      if ($urandom_range(0, 29) == 0) i_tx_done = 1'b1;
    end

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of byte requesters sharing one UART transmitter, range 2..8.
REQ-002 Parameter DBIT, default 8: data bits per frame.
REQ-003 Parameter GAP_TICKS, default 16: idle ticks inserted after each frame; 16 ticks is one bit time at 16x sampling.
REQ-004 Parameter TIMEOUT_TICKS, default 2048: maximum ticks allowed in BUSY before the frame is aborted.
REQ-005 i_clk  input  1  the single clock; all logic is rising-edge.
REQ-006 i_reset  input  1  asynchronous, active-low reset.
REQ-007 i_tick  input  1  one-cycle pulse from the baud-rate tick generator.
REQ-008 i_req  input  N_REQ  per-requester request level.
REQ-009 i_data  input  N_REQ*DBIT  flattened request bytes; requester k occupies bits [k*DBIT +: DBIT].
REQ-010 o_ack  output  N_REQ  one-cycle pulse on the granted requester when its byte is latched.
REQ-011 o_tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 o_tx_data  output  DBIT  byte to transmit; held stable from START until the next grant.
REQ-013 i_tx_done  input  1  one-cycle frame-complete pulse from the transmitter.
REQ-014 o_grant_id  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_err  output  1  one-cycle pulse when a frame is aborted on timeout.

Function
REQ-017 The FSM SHALL have four states: IDLE, START, BUSY and GAP.
REQ-018 IDLE with i_req != 0: on the next edge, latch the winner's byte into o_tx_data, load o_grant_id, pulse o_ack[winner] for one cycle, and go to START.
REQ-019 The winner SHALL be chosen round-robin: the first requester with i_req set, searching upward from the priority pointer and wrapping at N_REQ-1.
REQ-020 At each grant the priority pointer SHALL become (winner+1) mod N_REQ.
REQ-021 START SHALL assert o_tx_start for exactly one cycle, then go to BUSY unconditionally.
REQ-022 i_tx_done SHALL be sampled only in BUSY; in any other state it is ignored.
REQ-023 BUSY with i_tx_done high: go to GAP with the gap counter loaded to GAP_TICKS-1, or go straight to IDLE if GAP_TICKS = 0.
REQ-024 BUSY timeout counter: reset to 0 on entry and incremented on i_tick.
REQ-025 When the timeout counter reaches TIMEOUT_TICKS-1 and i_tick is high, with no i_tx_done: pulse o_err for one cycle and go to GAP.
REQ-026 If i_tx_done and the timeout condition occur in the same cycle, i_tx_done wins and o_err is not asserted.
REQ-027 GAP: the gap counter decrements on i_tick; when the counter = 0 and i_tick is high, go to IDLE.
REQ-028 Requests in GAP SHALL wait; a new grant is possible on the first IDLE cycle, giving one arbitration cycle between frames.
REQ-029 A requester SHALL hold i_req and i_data until its o_ack; a request dropped before grant is not considered.
REQ-030 A requester still requesting after its ack is treated as a new request.
REQ-031 All outputs SHALL be registered.
REQ-032 Counter widths: clog2(GAP_TICKS+1) for the gap counter and clog2(TIMEOUT_TICKS+1) for the timeout counter; both saturate, never wrap.

Reset
REQ-033 While i_reset = 0, the block SHALL be held in IDLE with: priority pointer = 0, o_ack = 0, o_tx_start = 0, o_tx_data = 0, o_grant_id = 0, o_busy = 0, o_err = 0, and both counters = 0.
REQ-034 Reset asserted mid-frame SHALL abort immediately with no o_err; after release the block arbitrates afresh from requester 0.

Structure
REQ-035 A shared package uart_pkg SHALL hold: the state encoding (IDLE=0, START=1, BUSY=2, GAP=3), the default GAP_TICKS, and the default TIMEOUT_TICKS.
REQ-036 The round-robin search SHALL be a combinational sub-module rr_arbiter with inputs req and pointer and outputs valid and winner index.

Verification
REQ-037 After reset, i_req=4'b0101: requester 0 is granted first with o_ack=4'b0001; requester 2 is granted next frame; then requester 0 again.
REQ-038 i_req=4'b1111 held for 8 frames: the grant sequence is 0,1,2,3,0,1,2,3 and each o_ack is exactly one cycle.
REQ-039 Grant byte 0xA5: o_tx_start pulses one cycle after o_ack; o_tx_data=0xA5 is stable until i_tx_done; o_busy drops exactly 16 ticks after done.
REQ-040 Never pulse i_tx_done with TIMEOUT_TICKS=32: o_err pulses on the 32nd tick in BUSY, then GAP runs and IDLE resumes.
REQ-041 i_tx_done and the timeout occur in the same cycle: no o_err and normal GAP entry.
REQ-042 Reset asserted in BUSY, then i_req=4'b1000 after release: all outputs are 0 during reset and requester 3 is granted with pointer restarting at 0.
